// File: rtl/adam_ramb_arbiter_if.sv
// Request/RAM-port bundle between the two DMA masters, the port-B arbiter and the RAM port.
// slave = arbiter view; master = the requesters plus the RAM, as driven by a bench or wrapper.
interface adam_ramb_arbiter_if #(
    parameter int AW = 16
);
    logic          req0_rd_i,   req1_rd_i;
    logic          req0_wr_i,   req1_wr_i;
    logic          req0_lock_i, req1_lock_i;
    logic [AW-1:0] req0_addr_i, req1_addr_i;
    logic [7:0]    req0_data_i, req1_data_i;
    logic          req0_ack_o,  req1_ack_o;
    logic          req0_err_o,  req1_err_o;
    logic [7:0]    rdata_o;
    logic [AW-1:0] ramb_addr_o;
    logic          ramb_wr_o,   ramb_rd_o;
    logic [7:0]    ramb_dout_o;
    logic [7:0]    ramb_din_i;
    logic          ramb_wr_ack_i, ramb_rd_ack_i;

    modport slave (
        input  req0_rd_i, req1_rd_i, req0_wr_i, req1_wr_i, req0_lock_i, req1_lock_i,
        input  req0_addr_i, req1_addr_i, req0_data_i, req1_data_i,
        input  ramb_din_i, ramb_wr_ack_i, ramb_rd_ack_i,
        output req0_ack_o, req1_ack_o, req0_err_o, req1_err_o, rdata_o,
        output ramb_addr_o, ramb_wr_o, ramb_rd_o, ramb_dout_o
    );

    modport master (
        output req0_rd_i, req1_rd_i, req0_wr_i, req1_wr_i, req0_lock_i, req1_lock_i,
        output req0_addr_i, req1_addr_i, req0_data_i, req1_data_i,
        output ramb_din_i, ramb_wr_ack_i, ramb_rd_ack_i,
        input  req0_ack_o, req1_ack_o, req0_err_o, req1_err_o, rdata_o,
        input  ramb_addr_o, ramb_wr_o, ramb_rd_o, ramb_dout_o
    );
endinterface

// File: rtl/adam_ramb_arbiter.sv
// Round-robin port-B sequencer shared by the SD DMA (0) and tape DMA (1); grant to ack is 3 cycles with a registered RAM ack.
// Requesters hold a level request until their ack pulse; a missing RAM ack ends in an error ack after TMO wait cycles.
module adam_ramb_arbiter #(
    parameter int AW  = 16,
    parameter int TMO = 15
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    adam_ramb_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_last;
    logic          r_lock;
    logic          r_wr;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_dout;
    logic [7:0]    r_rdata;
    logic          r_stb_wr, r_stb_rd;
    logic          r_ack0, r_ack1, r_err0, r_err1;

    logic w_pend0, w_pend1;
    logic w_gnt0, w_gnt1, w_gnt_wr;
    logic w_own_pend, w_own_lock;
    logic w_hit, w_fin_ok, w_fin_tmo;

    assign w_pend0 = bus.req0_rd_i | bus.req0_wr_i;
    assign w_pend1 = bus.req1_rd_i | bus.req1_wr_i;

    // r_last == 1 means requester 1 was served last, so requester 0 wins a tie.
    assign w_gnt0 = w_pend0 & (r_lock ? ~r_owner : (~w_pend1 | r_last));
    assign w_gnt1 = w_pend1 & (r_lock ?  r_owner : (~w_pend0 | ~r_last));
    assign w_gnt_wr = w_gnt1 ? bus.req1_wr_i : bus.req0_wr_i;

    assign w_own_pend = r_owner ? w_pend1 : w_pend0;
    assign w_own_lock = r_owner ? bus.req1_lock_i : bus.req0_lock_i;

    assign w_hit     = r_wr ? bus.ramb_wr_ack_i : bus.ramb_rd_ack_i;
    assign w_fin_ok  = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && w_hit;
    assign w_fin_tmo = (r_state == S_WAIT) && !w_hit && (r_cnt == 4'(TMO));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_lock   <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_dout   <= 8'h00;
            r_rdata  <= 8'h00;
            r_stb_wr <= 1'b0;
            r_stb_rd <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_stb_wr <= 1'b0;
            r_stb_rd <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            if (r_state == S_ISSUE) begin
                r_cnt <= 4'd0;
            end
            if (w_fin_ok || w_fin_tmo) begin
                r_state <= S_DONE;
                r_ack0  <= ~r_owner;
                r_ack1  <= r_owner;
                r_err0  <= w_fin_tmo & ~r_owner;
                r_err1  <= w_fin_tmo & r_owner;
                if (w_fin_tmo) begin
                    r_rdata <= 8'hFF;
                end else if (!r_wr) begin
                    r_rdata <= bus.ramb_din_i;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_gnt0 | w_gnt1) begin
                            r_owner  <= w_gnt1;
                            r_wr     <= w_gnt_wr;
                            r_addr   <= w_gnt1 ? bus.req1_addr_i : bus.req0_addr_i;
                            r_dout   <= w_gnt1 ? bus.req1_data_i : bus.req0_data_i;
                            r_stb_wr <= w_gnt_wr;
                            r_stb_rd <= ~w_gnt_wr;
                            r_state  <= S_ISSUE;
                        end else if (r_lock && !w_own_pend && !w_own_lock) begin
                            r_lock <= 1'b0;
                        end
                    end
                    S_ISSUE: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (r_cnt != 4'hF) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_DONE: begin
                        r_last  <= r_owner;
                        r_lock  <= w_own_lock;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ramb_addr_o = r_addr;
    assign bus.ramb_dout_o = r_dout;
    assign bus.ramb_wr_o   = r_stb_wr;
    assign bus.ramb_rd_o   = r_stb_rd;
    assign bus.rdata_o     = r_rdata;
    assign bus.req0_ack_o  = r_ack0;
    assign bus.req1_ack_o  = r_ack1;
    assign bus.req0_err_o  = r_err0;
    assign bus.req1_err_o  = r_err1;
endmodule

// File: tb/tb_adam_ramb_arbiter.sv
`timescale 1ns/1ps
module tb_adam_ramb_arbiter;
    localparam int AW  = 16;
    localparam int TMO = 15;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        lock;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    adam_ramb_arbiter_if #(.AW(AW)) bus ();
    adam_ramb_arbiter #(.AW(AW), .TMO(TMO)) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));

    // RAM port model: registered ack after ram_dly extra cycles, or same-cycle ack in fast mode
    logic [7:0]  mem     [0:65535];
    logic [7:0]  exp_mem [0:65535];
    bit          ram_fast, ram_mute, ram_cross;
    int          ram_dly;
    logic        pend_rd, pend_wr;
    int          pend_cnt;
    logic [7:0]  pend_dat;
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_dat;

    always @(posedge clk) begin
        if (bus.ramb_wr_o) mem[bus.ramb_addr_o] <= bus.ramb_dout_o;
        else if (bd_we)    mem[bd_addr] <= bd_dat;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rd <= 1'b0; pend_wr <= 1'b0; pend_cnt <= 0; pend_dat <= 8'h00;
        end else if ((bus.ramb_rd_o || bus.ramb_wr_o) && !ram_fast) begin
            pend_rd  <= bus.ramb_rd_o;
            pend_wr  <= bus.ramb_wr_o;
            pend_cnt <= ram_dly;
            pend_dat <= mem[bus.ramb_addr_o];
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
        end else begin
            pend_rd <= 1'b0; pend_wr <= 1'b0;
        end
    end

    assign bus.ramb_rd_ack_i = !ram_mute && ((pend_rd && pend_cnt == 0) || (ram_fast && bus.ramb_rd_o)
                                             || (ram_cross && pend_wr && pend_cnt != 0));
    assign bus.ramb_wr_ack_i = !ram_mute && ((pend_wr && pend_cnt == 0) || (ram_fast && bus.ramb_wr_o)
                                             || (ram_cross && pend_rd && pend_cnt != 0));
    assign bus.ramb_din_i    = ram_fast ? mem[bus.ramb_addr_o] : pend_dat;

    int n_chk = 0, n_fail = 0, n_wstb = 0, cyc = 0;
    op_t q0[$], q1[$];
    int  ack_log[$];
    bit  m_busy = 0, m_tmo = 0;
    int  m_own = 0, m_last = 1, m_lock = -1, m_grant = 0, m_due = 0;
    op_t m_op;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic op_t mk(input logic rd, input logic wr, input logic lock,
                               input logic [15:0] a, input logic [7:0] d);
        op_t o;
        o.rd = rd; o.wr = wr; o.lock = lock; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic int qsize(input int r);
        return (r == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int lat_of();
        if (ram_mute) return 3 + TMO;
        if (ram_fast) return 2;
        return 3 + ram_dly;
    endfunction

    task automatic drive();
        op_t h0, h1;
        h0 = '0; h1 = '0;
        if (q0.size() != 0) h0 = q0[0];
        if (q1.size() != 0) h1 = q1[0];
        // the owner's address/data wobble while granted; only the latched values may reach the RAM
        if (m_busy && m_own == 0) begin h0.addr = 16'($urandom); h0.data = 8'($urandom); end
        if (m_busy && m_own == 1) begin h1.addr = 16'($urandom); h1.data = 8'($urandom); end
        bus.req0_rd_i = h0.rd; bus.req0_wr_i = h0.wr; bus.req0_lock_i = h0.lock;
        bus.req0_addr_i = h0.addr; bus.req0_data_i = h0.data;
        bus.req1_rd_i = h1.rd; bus.req1_wr_i = h1.wr; bus.req1_lock_i = h1.lock;
        bus.req1_addr_i = h1.addr; bus.req1_data_i = h1.data;
    endtask

    // transaction-level arbitration: lock owner first, otherwise the requester not served last
    task automatic model_grant();
        int w;
        if (m_busy) return;
        if (m_lock >= 0 && qsize(m_lock) == 0) begin m_lock = -1; return; end
        if (q0.size() == 0 && q1.size() == 0) return;
        if (m_lock >= 0)                             w = m_lock;
        else if (q0.size() != 0 && q1.size() != 0)   w = 1 - m_last;
        else                                         w = (q0.size() != 0) ? 0 : 1;
        m_busy = 1; m_own = w; m_op = (w == 0) ? q0[0] : q1[0];
        m_grant = cyc; m_due = cyc + lat_of(); m_tmo = ram_mute;
    endtask

    task automatic observe();
        logic [1:0] stb;
        logic [3:0] flags;
        logic [3:0] eflags;
        stb   = {bus.ramb_wr_o, bus.ramb_rd_o};
        flags = {bus.req1_err_o, bus.req0_err_o, bus.req1_ack_o, bus.req0_ack_o};
        if (bus.ramb_wr_o) n_wstb++;
        if (m_busy && cyc == m_grant + 1) begin
            check_eq("strobe_dir", 32'(stb), m_op.wr ? 32'h2 : 32'h1);
            check_eq("strobe_addr", 32'(bus.ramb_addr_o), 32'(m_op.addr));
            if (m_op.wr) check_eq("strobe_dout", 32'(bus.ramb_dout_o), 32'(m_op.data));
        end else begin
            check_eq("strobe_quiet", 32'(stb), 32'h0);
        end
        if (m_busy && cyc == m_due) begin
            eflags = {m_tmo && m_own == 1, m_tmo && m_own == 0, m_own == 1, m_own == 0};
            check_eq("ack_flags", 32'(flags), 32'(eflags));
            if (!m_op.wr) check_eq("rdata", 32'(bus.rdata_o), m_tmo ? 32'hFF : 32'(exp_mem[m_op.addr]));
            else          exp_mem[m_op.addr] = m_op.data;
            ack_log.push_back(m_own);
            m_last = m_own;
            m_lock = m_op.lock ? m_own : -1;
            if (m_own == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            m_busy = 0;
        end else begin
            check_eq("ack_quiet", 32'(flags), 32'h0);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        drive();
        model_grant();
        @(negedge clk);
        observe();
    endtask

    task automatic run_scn(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy) && n < budget) begin
            step(); n++;
        end
        check_eq("scn_drained", 32'(q0.size() + q1.size() + int'(m_busy)), 32'h0);
        step(); step();
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_addr = a; bd_dat = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_addr"},  32'(bus.ramb_addr_o), 32'h0);
        check_eq({tag, "_dout"},  32'(bus.ramb_dout_o), 32'h0);
        check_eq({tag, "_stb"},   32'({bus.ramb_wr_o, bus.ramb_rd_o}), 32'h0);
        check_eq({tag, "_rdata"}, 32'(bus.rdata_o), 32'h0);
        check_eq({tag, "_flags"}, 32'({bus.req1_err_o, bus.req0_err_o, bus.req1_ack_o, bus.req0_ack_o}), 32'h0);
    endtask

    initial begin
        int base, k, n;
        bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
        ram_fast = 0; ram_mute = 0; ram_cross = 0; ram_dly = 0;
        drive();
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 16; i++) preload(16'h2000 + 16'(i), 8'($urandom));

        // single read
        preload(16'h0100, 8'h5A);
        ack_log.delete();
        q0.push_back(mk(1, 0, 0, 16'h0100, 8'h00));
        run_scn(40);
        check_eq("single_owner", 32'(ack_log.size() == 1 && ack_log[0] == 0), 32'h1);

        // write then read back on requester 1
        base = n_wstb;
        q1.push_back(mk(0, 1, 0, 16'h7FFF, 8'hC3));
        q1.push_back(mk(1, 0, 0, 16'h7FFF, 8'h00));
        run_scn(40);
        check_eq("wr_strobes", 32'(n_wstb - base), 32'h1);

        // contention: alternating grants starting with requester 0
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1, 0, 0, 16'h2000 + 16'(i), 8'h00));
            q1.push_back(mk(1, 0, 0, 16'h2008 + 16'(i), 8'h00));
        end
        run_scn(80);
        check_eq("rr_count", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_eq("rr_order", 32'(ack_log[i]), 32'(i % 2));

        // lock burst on requester 0 while requester 1 waits
        ack_log.delete();
        for (int i = 0; i < 4; i++) q0.push_back(mk(1, 0, (i < 3), 16'h2004 + 16'(i), 8'h00));
        q1.push_back(mk(1, 0, 0, 16'h200C, 8'h00));
        q1.push_back(mk(1, 0, 0, 16'h200D, 8'h00));
        run_scn(80);
        check_eq("lock_count", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) check_eq("lock_order", 32'(ack_log[i]), (i < 4) ? 32'd0 : 32'd1);

        // timeout with the RAM ack missing, then a normal transaction
        ram_mute = 1;
        q0.push_back(mk(1, 0, 0, 16'h2001, 8'h00));
        run_scn(60);
        ram_mute = 0;
        q0.push_back(mk(1, 0, 0, 16'h2002, 8'h00));
        run_scn(40);

        // randomized batches: ack delay, same-cycle ack, wrong-direction acks, locks, rd+wr together
        for (int b = 0; b < 8; b++) begin
            ram_fast  = ($urandom_range(0, 3) == 0);
            ram_dly   = ram_fast ? 0 : int'($urandom_range(0, 3));
            ram_cross = !ram_fast && ram_dly > 0 && ($urandom_range(0, 1) == 1);
            for (int r = 0; r < 2; r++) begin
                n = int'($urandom_range(2, 6));
                for (int i = 0; i < n; i++) begin
                    k = int'($urandom_range(0, 2));
                    if (r == 0) q0.push_back(mk(k != 1, k != 0, $urandom_range(0, 3) == 0,
                                                16'h2000 + 16'($urandom_range(0, 15)), 8'($urandom)));
                    else        q1.push_back(mk(k != 1, k != 0, $urandom_range(0, 3) == 0,
                                                16'h2000 + 16'($urandom_range(0, 15)), 8'($urandom)));
                end
            end
            run_scn(400);
        end

        // async reset during WAIT, after requester 0 was served last
        ram_fast = 0; ram_cross = 0; ram_dly = 3;
        q0.push_back(mk(1, 0, 0, 16'h2003, 8'h00));
        run_scn(40);
        q0.push_back(mk(1, 0, 0, 16'h2005, 8'h00));
        n = 0;
        do begin step(); n++; end while (!(m_busy && cyc == m_grant + 2) && n < 20);
        check_eq("wait_addr", 32'(bus.ramb_addr_o), 32'h2005);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        q0.delete(); q1.delete();
        m_busy = 0; m_last = 1; m_lock = -1;
        drive();
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ram_dly = 0;
        ack_log.delete();
        q0.push_back(mk(1, 0, 0, 16'h2006, 8'h00));
        q1.push_back(mk(1, 0, 0, 16'h2007, 8'h00));
        run_scn(40);
        check_eq("post_reset_count", 32'(ack_log.size()), 32'd2);
        check_eq("post_reset_first", 32'(ack_log[0]), 32'd0);
        check_eq("post_reset_second", 32'(ack_log[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
